// File: rtl/bus_master_tx.sv
// bus_master_tx: 4-deep word FIFO feeding a valid/ack bus master.
// Define BUS_MASTER_RETRY_EN to re-send timed-out words up to 2 more times.
module bus_master_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_data,
    output logic       req_ready,
    input  logic       dAck,
    output logic       dValid,
    output logic [7:0] data,
    output logic [2:0] fifo_level,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] mem [0:3];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] beat;
    logic       ready_en;
    logic       push;
    logic       pop;
    logic       tmo;
    logic       again;

    assign dValid    = (state == XFER);
    assign req_ready = ready_en & ((fifo_level != 3'd4) | pop);
    assign push      = req_valid & req_ready;

    // Upstream is held off until the first clock after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Storage array; entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= req_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= 2'd0;
            rptr       <= 2'd0;
            fifo_level <= 3'd0;
        end else begin
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            fifo_level <= fifo_level + {2'b00, push} - {2'b00, pop};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, FIFO pop and timeout detection
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != 3'd0) begin
                    pop     = 1'b1;
                    state_n = XFER;
                end
            end
            XFER: begin
                if ((beat >= 3'd2) && dAck) begin
                    state_n = GAP;
                end else if (beat == 3'd4) begin
                    tmo     = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (again) begin
                    state_n = XFER;
                end else if (fifo_level != 3'd0) begin
                    pop     = 1'b1;
                    state_n = XFER;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus data, beat counter and timeout pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data        <= 8'h00;
            beat        <= 3'd0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= tmo;
            if (pop) begin
                data <= mem[rptr];
            end
            if (state_n != XFER) begin
                beat <= 3'd0;
            end else if (state != XFER) begin
                beat <= 3'd1;
            end else if (beat != 3'd4) begin
                beat <= beat + 3'd1;
            end
        end
    end

`ifdef BUS_MASTER_RETRY_EN
    logic [1:0] tries;

    // Retry bookkeeping: a timed-out word is kept for up to two re-sends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tries <= 2'd0;
            again <= 1'b0;
        end else begin
            again <= tmo && (tries != 2'd2);
            if (pop) begin
                tries <= 2'd0;
            end else if (tmo && (tries != 2'd2)) begin
                tries <= tries + 2'd1;
            end
        end
    end
`else
    assign again = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_tx.sv
// tb_bus_master_tx: vector table for single transfers plus
// hand-written FIFO-full and mid-transfer reset sequences.
module tb_bus_master_tx;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic       dAck;
    logic       dValid;
    logic [7:0] data;
    logic [2:0] fifo_level;
    logic       err_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic       e_dv;
        logic [7:0] e_data;
        logic [2:0] e_lvl;
        logic       e_rdy;
        logic       e_tmo;
    } vec_t;

    vec_t tbl[$];

    bus_master_tx dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .dAck       (dAck),
        .dValid     (dValid),
        .data       (data),
        .fifo_level (fifo_level),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic [7:0] words [0:4];
    int   idx, seen, pulses, maxlvl;
    logic acc, prev_dv, full_stall, any_dv;

    initial begin
        // single transfers: ack@2, ack@1 ignored then @3, timeout, back-to-back
        tbl.push_back('{1, 8'hA5, 0, 0, 8'h00, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'hA5, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'hA5, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 8'hA5, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 8'hA5, 0, 1, 0});
        tbl.push_back('{1, 8'h3C, 0, 0, 8'hA5, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h3C, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 1, 8'h3C, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h3C, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h3C, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 8'h3C, 0, 1, 0});
        tbl.push_back('{1, 8'h77, 0, 0, 8'h3C, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h77, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h77, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h77, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h77, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 8'h77, 0, 1, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 8'h77, 0, 1, 0});
        tbl.push_back('{1, 8'h10, 0, 0, 8'h77, 1, 1, 0});
        tbl.push_back('{1, 8'h20, 0, 1, 8'h10, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h10, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h10, 1, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h20, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 1, 8'h20, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 8'h20, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 8'h20, 0, 1, 0});

        reset     = 1'b0;
        req_valid = 1'b0;
        req_data  = 8'h00;
        dAck      = 1'b0;
        tick();
        tick();
        chk("rst dValid", {7'd0, dValid}, 8'd0);
        chk("rst data", data, 8'h00);
        chk("rst level", {5'd0, fifo_level}, 8'd0);
        chk("rst ready", {7'd0, req_ready}, 8'd0);
        chk("rst tmo", {7'd0, err_timeout}, 8'd0);
        reset = 1'b1;
        #1;
        chk("ready before edge", {7'd0, req_ready}, 8'd0);
        tick();
        chk("ready after edge", {7'd0, req_ready}, 8'd1);

        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            dAck      = tbl[i].ack;
            tick();
            chk($sformatf("row%0d dValid", i), {7'd0, dValid},
                {7'd0, tbl[i].e_dv});
            chk($sformatf("row%0d data", i), data, tbl[i].e_data);
            chk($sformatf("row%0d level", i), {5'd0, fifo_level},
                {5'd0, tbl[i].e_lvl});
            chk($sformatf("row%0d ready", i), {7'd0, req_ready},
                {7'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d tmo", i), {7'd0, err_timeout},
                {7'd0, tbl[i].e_tmo});
        end

        // five words pushed back to back, never acknowledged
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        words[3] = 8'h04;
        words[4] = 8'h05;
        idx        = 0;
        seen       = 0;
        pulses     = 0;
        maxlvl     = 0;
        prev_dv    = 1'b0;
        full_stall = 1'b0;
        dAck       = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (seen == 5 && pulses == 5) break;
            if (idx < 5) begin
                req_valid = 1'b1;
                req_data  = words[idx];
            end else begin
                req_valid = 1'b0;
            end
            acc = req_valid & req_ready;
            tick();
            if (acc) idx++;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (fifo_level == 3'd4 && dValid && !req_ready)
                full_stall = 1'b1;
            if (err_timeout) pulses++;
            if (dValid && !prev_dv) begin
                if (seen < 5)
                    chk($sformatf("order%0d", seen), data, words[seen]);
                seen++;
            end
            prev_dv = dValid;
        end
        req_valid = 1'b0;
        chk("full level", maxlvl[7:0], 8'd4);
        chk("full stall", {7'd0, full_stall}, 8'd1);
        chk("bursts seen", seen[7:0], 8'd5);
        chk("timeout pulses", pulses[7:0], 8'd5);
        tick();
        tick();

        // reset during beat 3 of 8'hEE with two words queued
        req_valid = 1'b1;
        req_data  = 8'hEE;
        tick();
        req_data = 8'h11;
        tick();
        req_data = 8'h22;
        tick();
        req_valid = 1'b0;
        tick();
        chk("b3 dValid", {7'd0, dValid}, 8'd1);
        chk("b3 data", data, 8'hEE);
        chk("b3 level", {5'd0, fifo_level}, 8'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async dValid", {7'd0, dValid}, 8'd0);
        chk("async level", {5'd0, fifo_level}, 8'd0);
        chk("async ready", {7'd0, req_ready}, 8'd0);
        chk("async data", data, 8'h00);
        @(posedge clk);
        #3;
        reset  = 1'b1;
        any_dv = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dValid) any_dv = 1'b1;
        end
        chk("post-rst no xfer", {7'd0, any_dv}, 8'd0);
        chk("post-rst level", {5'd0, fifo_level}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
